// File: rtl/aes_ct_serializer_pkg.sv
// Shared constants and helpers for the masked AES ciphertext output path.
// The share-index helper fixes the bit-interleaved sharing layout used by every masked block.
package aes_ct_serializer_pkg;

  localparam int unsigned D_DEFAULT  = 2;
  localparam int unsigned BLOCK_BITS = 128;

  function automatic int unsigned calc_nbeats(input int unsigned beat_bits);
    return BLOCK_BITS / beat_bits;
  endfunction

  function automatic int unsigned calc_beat_w(input int unsigned nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

  // Bit i of share j lives at i*d+j.
  function automatic int unsigned share_idx(input int unsigned i, input int unsigned j,
                                            input int unsigned d);
    return i * d + j;
  endfunction

endpackage

// File: rtl/aes_ct_serializer_if.sv
// Ciphertext capture and beat-stream signals between the AES core, serializer and consumer.
// The slave view is the serializer; the master view drives ciphertext and accepts beats.
interface aes_ct_serializer_if
  import aes_ct_serializer_pkg::*;
#(
  parameter int unsigned D         = D_DEFAULT,
  parameter int unsigned BEAT_BITS = 32
) ();

  logic                      cipher_valid;
  logic [BLOCK_BITS*D-1:0]   sh_ciphertext;
  logic                      out_valid;
  logic                      out_ready;
  logic [BEAT_BITS*D-1:0]    out_data;
  logic                      out_last;

  modport slave (
    input  cipher_valid,
    input  sh_ciphertext,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_last
  );

  modport master (
    output cipher_valid,
    output sh_ciphertext,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/msk_beat_select.sv
// Combinational beat slicer for a shared block: picks beat beat_i and gates every share by en_i,
// so a disabled output carries the all-zero sharing rather than stale shares.
module msk_beat_select
  import aes_ct_serializer_pkg::*;
#(
  parameter int unsigned D         = D_DEFAULT,
  parameter int unsigned BEAT_BITS = 32,
  parameter int unsigned NBEATS    = calc_nbeats(BEAT_BITS),
  parameter int unsigned BeatW     = calc_beat_w(NBEATS)
) (
  input  logic [BLOCK_BITS*D-1:0] data_i,
  input  logic [BeatW-1:0]        beat_i,
  input  logic                    en_i,
  output logic [BEAT_BITS*D-1:0]  data_o
);

  localparam int unsigned SliceW = BEAT_BITS * D;

  logic [SliceW-1:0] sel;

  always_comb begin
    sel = '0;
    for (int k = 0; k < int'(NBEATS); k++) begin
      if (beat_i == BeatW'(k)) begin
        sel = data_i[k*SliceW +: SliceW];
      end
    end
  end

  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < BEAT_BITS; i++) begin
      for (int unsigned j = 0; j < D; j++) begin
        data_o[share_idx(i, j, D)] = sel[share_idx(i, j, D)] & en_i;
      end
    end
  end

endmodule

// File: rtl/aes_ct_serializer.sv
// Two-entry masked buffer between the AES core and a beat stream; captures ciphertext on the
// core's valid pulse and drains it beat by beat without ever stalling or recombining shares.
module aes_ct_serializer
  import aes_ct_serializer_pkg::*;
#(
  parameter int unsigned D         = D_DEFAULT,
  parameter int unsigned BEAT_BITS = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  aes_ct_serializer_if.slave  bus,
  output logic                overrun_o,
  output logic                empty_o
);

  localparam int unsigned NBEATS = calc_nbeats(BEAT_BITS);
  localparam int unsigned BeatW  = calc_beat_w(NBEATS);
  localparam int unsigned EntryW = BLOCK_BITS * D;

  logic [EntryW-1:0] entry_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [BeatW-1:0]  beat_q;
  logic              overrun_q;

  logic valid;
  logic last;
  logic xfer;
  logic pop;
  logic push;

  always_comb begin
    valid = (count_q != 2'd0);
    last  = valid & (beat_q == BeatW'(NBEATS - 1));
    xfer  = valid & bus.out_ready;
    pop   = xfer & last;
    // A full buffer still accepts when the head block leaves in the same cycle.
    push  = bus.cipher_valid & ((count_q != 2'd2) | pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q   <= '{default: '0};
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      beat_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) begin
        entry_q[wr_ptr_q] <= bus.sh_ciphertext;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (xfer) begin
        if (last) begin
          beat_q   <= '0;
          rd_ptr_q <= ~rd_ptr_q;
        end else begin
          beat_q <= beat_q + BeatW'(1);
        end
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (bus.cipher_valid && !push) begin
        overrun_q <= 1'b1;
      end
    end
  end

  msk_beat_select #(
    .D         (D),
    .BEAT_BITS (BEAT_BITS)
  ) u_beat_select (
    .data_i (entry_q[rd_ptr_q]),
    .beat_i (beat_q),
    .en_i   (valid),
    .data_o (bus.out_data)
  );

  assign bus.out_valid = valid;
  assign bus.out_last  = last;
  assign overrun_o     = overrun_q;
  assign empty_o       = ~valid;

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Randomized and directed bench for aes_ct_serializer against a queue-based reference model.
module tb_aes_ct_serializer;

  localparam int unsigned D      = 2;
  localparam int unsigned BB     = 32;
  localparam int unsigned NBEATS = 128 / BB;
  localparam int unsigned SW     = BB * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overrun;
  logic empty;

  always #5 clk = ~clk;

  aes_ct_serializer_if #(.D(D), .BEAT_BITS(BB)) bus_if ();

  aes_ct_serializer #(
    .D         (D),
    .BEAT_BITS (BB)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus_if),
    .overrun_o (overrun),
    .empty_o   (empty)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model: FIFO of stored blocks (shared form and plain ciphertext).
  logic [255:0] mq[$];
  logic [127:0] cq[$];
  int           mbeat = 0;
  bit           movf  = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] share_vec(input logic [127:0] s0, input logic [127:0] s1);
    logic [255:0] v;
    for (int i = 0; i < 128; i++) begin
      v[2*i]   = s0[i];
      v[2*i+1] = s1[i];
    end
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input logic cv, input logic [127:0] s0, input logic [127:0] s1,
                      input logic rdy, input logic r);
    bit           exp_valid;
    logic [SW-1:0] exp_data;
    logic [SW-1:0] got;
    logic [BB-1:0] word;
    bit           pop;
    int           sz;
    @(negedge clk);
    exp_valid = (mq.size() != 0);
    exp_data  = exp_valid ? mq[0][mbeat*SW +: SW] : '0;
    if (chk_on) begin
      check_eq("out_valid", 128'(bus_if.out_valid), 128'(exp_valid));
      check_eq("out_data", 128'(bus_if.out_data), 128'(exp_data));
      check_eq("out_last", 128'(bus_if.out_last),
               128'(exp_valid && (mbeat == int'(NBEATS) - 1)));
      check_eq("empty", 128'(empty), 128'(!exp_valid));
      check_eq("overrun", 128'(overrun), 128'(movf));
      if (exp_valid && rdy && !r) begin
        got = bus_if.out_data;
        for (int i = 0; i < int'(BB); i++) word[i] = got[2*i] ^ got[2*i+1];
        check_eq("xor_word", 128'(word), 128'(cq[0][mbeat*BB +: BB]));
      end
    end
    bus_if.cipher_valid  = cv;
    bus_if.sh_ciphertext = share_vec(s0, s1);
    bus_if.out_ready     = rdy;
    rst                  = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      cq.delete();
      mbeat = 0;
      movf  = 1'b0;
    end else begin
      sz  = mq.size();
      pop = (sz != 0) && rdy && (mbeat == int'(NBEATS) - 1);
      if (sz != 0 && rdy) begin
        if (pop) begin
          void'(mq.pop_front());
          void'(cq.pop_front());
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
      if (cv) begin
        if (sz < 2 || pop) begin
          mq.push_back(share_vec(s0, s1));
          cq.push_back(s0 ^ s1);
        end else begin
          movf = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy, 1'b0);
  endtask

  task automatic push_blk(input logic rdy);
    step(1'b1, rnd128(), rnd128(), rdy, 1'b0);
  endtask

  initial begin
    logic [127:0] a0;
    bus_if.cipher_valid  = 1'b0;
    bus_if.sh_ciphertext = '0;
    bus_if.out_ready     = 1'b0;
    a0 = 128'h00112233445566778899AABBCCDDEEFF;

    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    chk_on = 1'b1;

    // Single block with a fixed share 0.
    step(1'b1, a0, rnd128(), 1'b1, 1'b0);
    idle(1'b1, 6);

    // Backpressure during drain.
    push_blk(1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1'b1, 4);

    // Back-to-back blocks stored before draining.
    push_blk(1'b0);
    idle(1'b0, 1);
    push_blk(1'b0);
    idle(1'b0, 2);
    idle(1'b1, 10);

    // Overrun: third block dropped, overrun sticky until reset.
    push_blk(1'b0);
    push_blk(1'b0);
    push_blk(1'b0);
    idle(1'b0, 2);
    idle(1'b1, 10);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Full buffer with a push on the final beat of the head block.
    push_blk(1'b0);
    push_blk(1'b0);
    idle(1'b1, 3);
    push_blk(1'b1);
    idle(1'b1, 10);

    // Reset mid-drain, then a fresh block starts at beat 0.
    push_blk(1'b1);
    idle(1'b1, 2);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b1, 1);
    push_blk(1'b1);
    idle(1'b1, 6);

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) == 0), rnd128(), rnd128(), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 149) == 0));
    end
    idle(1'b1, 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_ct_serializer.md
Name: aes_ct_serializer

Overview:
- Sits directly downstream of the masked round-based AES-128 core.
- Captures each shared 128-bit ciphertext on the core's one-cycle cipher_valid pulse and buffers it in a 2-entry masked buffer.
- Drains each buffer entry over a valid/ready stream as NBEATS beats of BEAT_BITS bits per share.
- Shares are never recombined. The block is pure storage and selection, so the core is never stalled.

Parameters:
- d, 2, number of shares (masking order + 1).
- BEAT_BITS, 32, bits per share per output beat; must divide 128.
- NBEATS, 128/BEAT_BITS, beats per block; derived, not overridable.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- cipher_valid  in  1  one-cycle pulse from the core; sh_ciphertext is valid in that cycle.
- sh_ciphertext  in  128*d  shared ciphertext; bit i of share j is at index i*d+j.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  BEAT_BITS*d  beat k = sh_ciphertext slice [(BEAT_BITS*(k+1))*d-1 : BEAT_BITS*k*d], share layout unchanged.
- out_last  out  1  high on the final beat (k=NBEATS-1) of a block.
- overrun  out  1  sticky: a block was dropped because the buffer was full.
- empty  out  1  no block buffered.

Behaviour:
- Reset (synchronous, active-high) is taken on a clk edge with rst=1. It has priority over all other events, including mid-drain.
- Reset values:
  - count=0, wr_ptr=0, rd_ptr=0, beat=0.
  - out_valid=0, out_last=0, overrun=0, empty=1.
  - Buffer contents are cleared to all-zero sharing.
- Storage: 2 entries of 128*d bits, 1-bit wr_ptr and rd_ptr, count in 0..2, beat counter in 0..NBEATS-1.
- Push: cipher_valid=1 and accepted, so entry[wr_ptr] <= sh_ciphertext, wr_ptr toggles, and count increments.
- Latency: a push in cycle t gives out_valid=1 in cycle t+1 if the buffer was empty.
- out_valid = (count != 0).
- out_data = slice beat of entry[rd_ptr] when out_valid=1. Otherwise it is forced to all-zero sharing by a share-wise AND mask, so no stale shares appear on the bus.
- out_last = out_valid & (beat == NBEATS-1).
- Handshake:
  - A beat transfers when out_valid & out_ready.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - Each transfer increments beat.
  - A transfer with out_last=1 sets beat to 0, toggles rd_ptr and decrements count (pop).
- Simultaneous push and pop in one cycle: count is unchanged and both pointers toggle.
- Full (count=2) with cipher_valid=1:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the block is dropped, overrun <= 1, and the stored entries and pointers are unchanged.
  - overrun clears only on reset.
- Empty with out_ready=1: no transfer and no state change.
- A popped entry is not cleared. Masking relies on output gating only.
- empty = (count == 0).
- Control logic (pointers, counters, flags) is plain registers. No control signal depends on share values.

Decomposition:
- Shared package holds:
  - D_DEFAULT and BLOCK_BITS=128.
  - The function computing NBEATS from BEAT_BITS.
  - The share-index helper (i*d+j) used by all masked blocks.
- One sub-module: msk_beat_select. It is combinational: given 128*d input, beat index and enable, it outputs the BEAT_BITS*d slice AND-gated share-wise by enable.
- The top holds the buffer, pointers and FSM counters.

Test Plan:
- Single block: rst 2 cycles, one cipher_valid with shares A (share0=128'h0011..EEFF, share1=random), out_ready=1. Required: out_valid from next cycle for 4 beats, out_last on beat 3, XOR of shares per beat equals ciphertext word k, then empty=1.
- Backpressure: out_ready toggled 1,0,0,1 during drain. Required: out_data and out_last held while ready=0, exactly 4 transfers, no duplication.
- Back-to-back: pulses for blocks B1 and B2 two cycles apart, out_ready=0 until both stored. Required: count=2, then B1 beats 0-3 followed by B2 beats 0-3 in order.
- Overrun: three pulses with out_ready=0. Required: overrun=1 after the 3rd, buffer holds B1 and B2, and the drain emits only B1 and B2.
- Full plus push during final pop: count=2 and beat 3 transferring in the same cycle as cipher_valid. Required: B3 accepted, overrun=0, order B1,B2,B3.
- Reset mid-drain: assert rst after beat 1 of B1. Required: next cycle out_valid=0, out_data=0, empty=1, overrun=0. A new block drains from beat 0.
